// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Default widths, MDU latencies and Tnew/Tuse encodings.
package hazard_scoreboard_pkg;

    localparam int PKG_REG_AW = 5;
    localparam int PKG_TNEW_W = 2;

    // Write descriptor at the default widths
    typedef struct packed {
        logic                  valid;
        logic [PKG_REG_AW-1:0] dst;
        logic [PKG_TNEW_W-1:0] tnew;
    } desc_t;

    localparam int SEL_GRF = 0;

    localparam int MULT_LAT_C = 5;
    localparam int DIV_LAT_C  = 10;

    // Tnew measured at E entry
    localparam logic [PKG_TNEW_W-1:0] TNEW_JAL  = 2'd0;
    localparam logic [PKG_TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [PKG_TNEW_W-1:0] TNEW_LOAD = 2'd2;

    // Tuse measured at D
    localparam logic [PKG_TNEW_W-1:0] TUSE_BRANCH = 2'd0;
    localparam logic [PKG_TNEW_W-1:0] TUSE_ALU    = 2'd1;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Priority match of one source register against the write pipeline.
// Lowest stage index at or above LO wins; $0 never matches.
module hs_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int N  = 3,
    parameter int LO = 0,
    parameter int AW = 5,
    parameter int TW = 2,
    parameter int IW = 3
) (
    input  logic [AW-1:0]        src_i,
    input  logic                 use_i,
    input  logic [N-1:0]         vld_i,
    input  logic [N-1:0][AW-1:0] dst_i,
    input  logic [N-1:0][TW-1:0] tnew_i,
    output logic                 hit_o,
    output logic [IW-1:0]        idx_o,
    output logic [TW-1:0]        tnew_o
);

    // Scan oldest to youngest so the nearest match overwrites
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        tnew_o = '0;
        for (int k = N - 1; k >= LO; k--) begin
            if (use_i && src_i != '0 &&
                vld_i[k] && dst_i[k] == src_i) begin
                hit_o  = 1'b1;
                idx_o  = IW'(k);
                tnew_o = tnew_i[k];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: in-flight write pipeline, forward selects,
// data/MDU stall and the multiply/divide busy counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = PKG_REG_AW,
    parameter int TNEW_W     = PKG_TNEW_W,
    parameter int SEL_W      = 3,
    parameter int MULT_LAT   = MULT_LAT_C,
    parameter int DIV_LAT    = DIV_LAT_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic              d_wr_en,
    input  logic [REG_AW-1:0] d_wr_dst,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_is_mdu,
    input  logic              e_mdu_start,
    input  logic              e_mdu_div,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_d_rs,
    output logic [SEL_W-1:0]  fwd_sel_d_rt,
    output logic [SEL_W-1:0]  fwd_sel_e_rs,
    output logic [SEL_W-1:0]  fwd_sel_e_rt,
    output logic              mdu_busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [NUM_STAGES-1:0]             vld_q, vld_d;
    logic [NUM_STAGES-1:0][REG_AW-1:0] dst_q, dst_d;
    logic [NUM_STAGES-1:0][TNEW_W-1:0] tnew_q, tnew_d;

    logic [REG_AW-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic              e_use_rs_q, e_use_rs_d;
    logic              e_use_rt_q, e_use_rt_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic              d_rs_hit, d_rt_hit, e_rs_hit, e_rt_hit;
    logic [SEL_W-1:0]  d_rs_idx, d_rt_idx, e_rs_idx, e_rt_idx;
    logic [TNEW_W-1:0] d_rs_tn, d_rt_tn, e_rs_tn, e_rt_tn;
    logic              d_rs_haz, d_rt_haz, mdu_stall;

    hs_match #(
        .N(NUM_STAGES), .LO(0), .AW(REG_AW), .TW(TNEW_W), .IW(SEL_W)
    ) u_m_d_rs (
        .src_i(d_rs), .use_i(d_use_rs),
        .vld_i(vld_q), .dst_i(dst_q), .tnew_i(tnew_q),
        .hit_o(d_rs_hit), .idx_o(d_rs_idx), .tnew_o(d_rs_tn)
    );

    hs_match #(
        .N(NUM_STAGES), .LO(0), .AW(REG_AW), .TW(TNEW_W), .IW(SEL_W)
    ) u_m_d_rt (
        .src_i(d_rt), .use_i(d_use_rt),
        .vld_i(vld_q), .dst_i(dst_q), .tnew_i(tnew_q),
        .hit_o(d_rt_hit), .idx_o(d_rt_idx), .tnew_o(d_rt_tn)
    );

    hs_match #(
        .N(NUM_STAGES), .LO(1), .AW(REG_AW), .TW(TNEW_W), .IW(SEL_W)
    ) u_m_e_rs (
        .src_i(e_rs_q), .use_i(e_use_rs_q),
        .vld_i(vld_q), .dst_i(dst_q), .tnew_i(tnew_q),
        .hit_o(e_rs_hit), .idx_o(e_rs_idx), .tnew_o(e_rs_tn)
    );

    hs_match #(
        .N(NUM_STAGES), .LO(1), .AW(REG_AW), .TW(TNEW_W), .IW(SEL_W)
    ) u_m_e_rt (
        .src_i(e_rt_q), .use_i(e_use_rt_q),
        .vld_i(vld_q), .dst_i(dst_q), .tnew_i(tnew_q),
        .hit_o(e_rt_hit), .idx_o(e_rt_idx), .tnew_o(e_rt_tn)
    );

    assign d_rs_haz  = d_rs_hit && (d_rs_tn > d_tuse_rs);
    assign d_rt_haz  = d_rt_hit && (d_rt_tn > d_tuse_rt);
    assign mdu_stall = d_is_mdu && (busy_q || e_mdu_start);
    assign stall     = rst_n && (d_rs_haz || d_rt_haz || mdu_stall);

    assign fwd_sel_d_rs = (d_rs_hit && d_rs_tn == '0) ?
                          d_rs_idx + 1'b1 : SEL_W'(SEL_GRF);
    assign fwd_sel_d_rt = (d_rt_hit && d_rt_tn == '0) ?
                          d_rt_idx + 1'b1 : SEL_W'(SEL_GRF);
    assign fwd_sel_e_rs = (e_rs_hit && e_rs_tn == '0) ?
                          e_rs_idx + 1'b1 : SEL_W'(SEL_GRF);
    assign fwd_sel_e_rt = (e_rt_hit && e_rt_tn == '0) ?
                          e_rt_idx + 1'b1 : SEL_W'(SEL_GRF);

    assign mdu_busy = busy_q;

    // Age descriptors one stage; stage 0 takes D or a bubble
    always_comb begin
        vld_d  = '0;
        dst_d  = '0;
        tnew_d = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            vld_d[k]  = vld_q[k-1];
            dst_d[k]  = dst_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
        end
        if (!stall) begin
            vld_d[0]  = d_wr_en && (d_wr_dst != '0);
            dst_d[0]  = d_wr_dst;
            tnew_d[0] = d_tnew;
        end
    end

    // E source tags follow D unless D is held back
    always_comb begin
        e_rs_d     = '0;
        e_rt_d     = '0;
        e_use_rs_d = 1'b0;
        e_use_rt_d = 1'b0;
        if (!stall) begin
            e_rs_d     = d_rs;
            e_rt_d     = d_rt;
            e_use_rs_d = d_use_rs;
            e_use_rt_d = d_use_rt;
        end
    end

    // MDU countdown; a new start always reloads
    always_comb begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (e_mdu_start)
            cnt_d = e_mdu_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        busy_d = (cnt_d != '0);
    end

    // All scoreboard state; reset drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            dst_q      <= '0;
            tnew_q     <= '0;
            e_rs_q     <= '0;
            e_rt_q     <= '0;
            e_use_rs_q <= 1'b0;
            e_use_rt_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            dst_q      <= dst_d;
            tnew_q     <= tnew_d;
            e_rs_q     <= e_rs_d;
            e_rt_q     <= e_rt_d;
            e_use_rs_q <= e_use_rs_d;
            e_use_rt_q <= e_use_rt_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
        end
    end

    // A producer still pending when its consumer reaches E means D missed a stall
    a_e_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(e_rs_hit && e_rs_tn != '0) && !(e_rt_hit && e_rt_tn != '0));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
// Inputs change 1 time unit after posedge; outputs sampled at negedge.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic [4:0] d_rs, d_rt, d_wr_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_use_rs, d_use_rt, d_wr_en, d_is_mdu;
    logic       e_mdu_start, e_mdu_div;
    logic       stall, mdu_busy;
    logic [2:0] fwd_sel_d_rs, fwd_sel_d_rt;
    logic [2:0] fwd_sel_e_rs, fwd_sel_e_rt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_wr_en(d_wr_en), .d_wr_dst(d_wr_dst), .d_tnew(d_tnew),
        .d_is_mdu(d_is_mdu),
        .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div),
        .stall(stall),
        .fwd_sel_d_rs(fwd_sel_d_rs), .fwd_sel_d_rt(fwd_sel_d_rt),
        .fwd_sel_e_rs(fwd_sel_e_rs), .fwd_sel_e_rt(fwd_sel_e_rt),
        .mdu_busy(mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0;
        d_use_rs = 0; d_use_rt = 0;
        d_wr_en = 0; d_wr_dst = 0; d_tnew = 0;
        d_is_mdu = 0; e_mdu_start = 0; e_mdu_div = 0;
    endtask

    task automatic wr(input logic [4:0] dst, input logic [1:0] tn);
        idle();
        d_wr_en = 1; d_wr_dst = dst; d_tnew = tn;
    endtask

    task automatic rd_rs(input logic [4:0] r, input logic [1:0] tu);
        idle();
        d_rs = r; d_use_rs = 1; d_tuse_rs = tu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        idle();
        repeat (4) tick();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_busy"}, 32'(mdu_busy), 0);
        chk({tag, "_sdrs"}, 32'(fwd_sel_d_rs), 0);
        chk({tag, "_sdrt"}, 32'(fwd_sel_d_rt), 0);
        chk({tag, "_sers"}, 32'(fwd_sel_e_rs), 0);
        chk({tag, "_sert"}, 32'(fwd_sel_e_rt), 0);
    endtask

    initial begin
        int nstall;
        idle();
        rst_n = 0;
        // stall must stay low in reset even with an MDU start pending
        d_is_mdu = 1; e_mdu_start = 1; e_mdu_div = 1;
        #2;
        all_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        idle();
        rst_n = 1;
        tick();

        // addu $3 then beq $3: one stall, then forward from M
        wr(5'd3, 2'd1);
        @(negedge clk); chk("alu_nostall", 32'(stall), 0);
        tick();
        rd_rs(5'd3, 2'd0);
        @(negedge clk); chk("alu_stall", 32'(stall), 1);
        tick();
        @(negedge clk); chk("alu_stall_end", 32'(stall), 0);
        chk("alu_sel_d_M", 32'(fwd_sel_d_rs), 2);
        tick();
        idle();
        @(negedge clk); chk("alu_sel_e_W", 32'(fwd_sel_e_rs), 3);
        flush();

        // lw $4 then addu $4 (tuse 1): one stall, then E picks W
        wr(5'd4, 2'd2);
        tick();
        rd_rs(5'd4, 2'd1);
        @(negedge clk); chk("ld_stall", 32'(stall), 1);
        tick();
        @(negedge clk); chk("ld_stall_end", 32'(stall), 0);
        chk("ld_sel_d_grf", 32'(fwd_sel_d_rs), 0);
        tick();
        idle();
        @(negedge clk); chk("ld_sel_e_W", 32'(fwd_sel_e_rs), 3);
        flush();

        // jal then jr $31: forward straight from E
        wr(5'd31, 2'd0);
        tick();
        rd_rs(5'd31, 2'd0);
        @(negedge clk); chk("jal_stall", 32'(stall), 0);
        chk("jal_sel_d_E", 32'(fwd_sel_d_rs), 1);
        tick();
        idle();
        @(negedge clk); chk("jal_sel_e_M", 32'(fwd_sel_e_rs), 2);
        flush();

        // two writes to $5: nearest stage wins on both sources
        wr(5'd5, 2'd0);
        tick();
        wr(5'd5, 2'd0);
        tick();
        rd_rs(5'd5, 2'd0);
        d_rt = 5'd5; d_use_rt = 1;
        @(negedge clk); chk("dup_stall", 32'(stall), 0);
        chk("dup_sel_rs", 32'(fwd_sel_d_rs), 1);
        chk("dup_sel_rt", 32'(fwd_sel_d_rt), 1);
        flush();

        // same pattern on $0 never forwards
        wr(5'd0, 2'd0);
        tick();
        wr(5'd0, 2'd1);
        tick();
        rd_rs(5'd0, 2'd0);
        @(negedge clk); chk("r0_stall", 32'(stall), 0);
        chk("r0_sel", 32'(fwd_sel_d_rs), 0);
        flush();

        // div start then mfhi: 11 stall cycles, busy for 10
        idle();
        e_mdu_start = 1; e_mdu_div = 1; d_is_mdu = 1;
        nstall = 0;
        @(negedge clk); chk("div_start_stall", 32'(stall), 1);
        chk("div_start_busy", 32'(mdu_busy), 0);
        if (stall) nstall++;
        tick();
        e_mdu_start = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("div_busy_%0d", i), 32'(mdu_busy), (i <= 10) ? 1 : 0);
            if (stall) nstall++;
            tick();
        end
        chk("div_stall_count", 32'(nstall), 11);
        flush();

        // mult then div while busy: div latency wins
        idle();
        e_mdu_start = 1;
        tick();
        e_mdu_start = 1; e_mdu_div = 1;
        @(negedge clk); chk("re_busy1", 32'(mdu_busy), 1);
        tick();
        idle();
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            if (i == 6 || i == 11 || i == 12)
                chk($sformatf("re_busy%0d", i), 32'(mdu_busy), (i <= 11) ? 1 : 0);
            tick();
        end
        flush();

        // reset in the middle of a stall clears everything at once
        wr(5'd7, 2'd2);
        e_mdu_start = 1;
        tick();
        rd_rs(5'd7, 2'd0);
        d_is_mdu = 1;
        @(negedge clk); chk("mr_stall", 32'(stall), 1);
        chk("mr_busy", 32'(mdu_busy), 1);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        all_zero("mr_async");
        tick();
        rst_n = 1;
        tick();
        all_zero("mr_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational forwarding unit.
- Keeps a registered shift pipeline of in-flight register-write descriptors (dest, Tnew) for the stages after D (E, M, W, ...).
- Compares D-stage and E-stage source operands (rs, rt, each with a Tuse) against that pipeline and produces per-source forward selects and a global stall/bubble.
- Also owns the multiply/divide busy counter and the MDU structural stall; sits beside the pipeline registers in the CPU top.

Parameters:
- NUM_STAGES, 3, producer stages tracked after D (index 0 = E, 1 = M, 2 = W, ...); range 2..6.
- REG_AW, 5, register address width.
- TNEW_W, 2, width of the Tnew/Tuse fields.
- SEL_W, 3, forward-select width; must satisfy 2^SEL_W > NUM_STAGES.
- MULT_LAT, 5, busy cycles loaded by a multiply start.
- DIV_LAT, 10, busy cycles loaded by a divide start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- d_rs, d_rt  in  REG_AW each  D-stage source register numbers.
- d_tuse_rs, d_tuse_rt  in  TNEW_W each  cycles until D needs each source.
- d_use_rs, d_use_rt  in  1 each  source is actually read.
- d_wr_en  in  1  D instruction writes a GPR.
- d_wr_dst  in  REG_AW  D destination register.
- d_tnew  in  TNEW_W  Tnew of the D instruction measured at E entry.
- d_is_mdu  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_mdu_start  in  1  E instruction starts mult (e_mdu_div=0) or div (e_mdu_div=1) this cycle.
- e_mdu_div  in  1  selects div latency when e_mdu_start is high.
- stall  out  1  hold PC and D; insert bubble into E.
- fwd_sel_d_rs, fwd_sel_d_rt  out  SEL_W each  D forward select: 0 = GRF, k+1 = stage k result.
- fwd_sel_e_rs, fwd_sel_e_rt  out  SEL_W each  E forward select: 0 = E-latched GRF value, k+1 = stage k (k ≥ 1).
- mdu_busy  out  1  MDU counter nonzero.

Behaviour:
- Reset clears every descriptor valid bit, the E source tags, the busy counter and mdu_busy. stall=0 and all selects=0 during and right after reset. Reset mid-operation discards all in-flight state with no partial drain.
- Descriptor fields: valid, dst, tnew. A descriptor is valid only if wr_en=1 and dst≠0.
- Each clock edge:
  - stage k+1 ← stage k with tnew decremented, saturating at 0.
  - stage 0 ← D descriptor when stall=0, otherwise a bubble (valid=0).
  - The last stage drops out.
- E source tags (rs, rt, use bits) are captured from D when stall=0 and cleared to a bubble when stall=1.
- Match rule for a source s against stage k: valid, dst==s, s≠0, use bit set. The nearest match (lowest k) wins; older matches are ignored.
- D source:
  - No match → sel 0.
  - Match with tnew==0 → sel k+1.
  - Match with tnew > tuse → stall (sel value don't-care).
  - Match with tnew ≤ tuse and tnew > 0 → sel 0; the E-stage select covers it next cycle.
- E source: searches stages 1..NUM_STAGES-1 only. Nearest match with tnew==0 → sel k+1, otherwise 0. A nonzero tnew at E is impossible when D stalled correctly; an assertion flags it.
- MDU counter:
  - e_mdu_start loads MULT_LAT or DIV_LAT.
  - Otherwise the counter decrements to 0.
  - mdu_busy = (count≠0) and is registered.
  - MDU stall when d_is_mdu and (mdu_busy or e_mdu_start).
  - A start while busy reloads the counter; the last start wins.
- stall = OR of the rs data hazard, the rt data hazard and the MDU stall. It is combinational from inputs and registered state, with no extra latency.
- Register $0 never matches. Simultaneous writes to the same dst in two stages resolve to the nearest stage.

Decomposition:
- Shared package holds:
  - descriptor typedef {valid, dst, tnew}.
  - constant SEL_GRF=0.
  - MDU latency constants.
  - TNEW/TUSE encodings (ALU=1, LOAD=2, JAL=0 at E).
- One natural sub-module, hs_match, instantiated four times: source vs. descriptor array → hit, stage index, tnew (priority encoder).

Test Plan:
- addu $3 (tnew=1) in D, next D beq $3 tuse=0 → stall=1 for one cycle; the cycle after, fwd_sel_d_rs=2 (M).
- lw $4 (tnew=2), next D addu rs=$4 tuse=1 → stall 1 cycle, then fwd_sel_e_rs=3 (W).
- jal (dst=31, tnew=0), next D jr $31 tuse=0 → stall=0, fwd_sel_d_rs=1 (E).
- Two in-flight writes to $5 in E and M with tnew=0, D reads $5 → sel=1 (nearest stage). Same pattern with dst=$0 → sel=0, stall=0.
- e_mdu_start with div=1, then mfhi in D → stall for exactly 11 cycles (the start cycle + 10 busy cycles); mdu_busy falls after 10 cycles.
- Mid-stall rst_n low → stall=0, mdu_busy=0 and all selects 0 asynchronously; still all 0 on the first edge after release.
